// File: rtl/rv_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and register-file read.
// The master drives instructions in and consumes decoded entries; the slave is the decode stage.
interface rv_decode_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [6:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [6:0]        funct7;
  logic [XLEN-1:0]   imm;
  logic [2:0]        fmt;
  logic              illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal
  );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I decode stage: field split, format classification, immediate generation,
// with a main register plus one skid entry so in_ready comes straight from a flop.
module rv_decode_stage #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int FENCE_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  rv_decode_stage_if.slave   bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
  } entry_t;

  state_t      state, state_n;
  entry_t      main_q, skid_q, dec;
  logic        in_ready_q;
  logic [31:0] ins;
  logic [31:0] imm32;
  logic [2:0]  dec_fmt;
  logic        accept, pop;
  logic        load_main, load_skid, skid_to_main;

  assign ins = bus.in_instr;

  always_comb begin
    dec_fmt = 3'd7;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:2])
        5'b01100:                               dec_fmt = 3'd0;
        5'b00100, 5'b00000, 5'b11001, 5'b11100: dec_fmt = 3'd1;
        5'b00011:                               dec_fmt = (FENCE_EN != 0) ? 3'd1 : 3'd7;
        5'b01000:                               dec_fmt = 3'd2;
        5'b11000:                               dec_fmt = 3'd3;
        5'b01101, 5'b00101:                     dec_fmt = 3'd4;
        5'b11011:                               dec_fmt = 3'd5;
        default:                                dec_fmt = 3'd7;
      endcase
    end
  end

  // Built at 32 bits first, then sign-extended so U-type also extends on RV64.
  always_comb begin
    imm32 = '0;
    case (dec_fmt)
      3'd1: imm32 = {{20{ins[31]}}, ins[31:20]};
      3'd2: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'd3: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd4: imm32 = {ins[31:12], 12'b0};
      3'd5: imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec.pc    = bus.in_pc;
    dec.instr = ins;
    dec.imm   = XLEN'($signed(imm32));
    dec.fmt   = dec_fmt;
  end

  assign accept = bus.in_valid & in_ready_q & ~bus.flush;
  assign pop    = (state != EMPTY) & bus.out_ready;

  always_comb begin
    state_n      = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (bus.flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_n   = ONE;
          load_main = 1'b1;
        end
        ONE: begin
          if (accept && !pop) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end else if (pop && !accept) begin
            state_n = EMPTY;
          end else if (accept && pop) begin
            load_main = 1'b1;
          end
        end
        FULL: if (pop) begin
          state_n      = ONE;
          skid_to_main = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != FULL);
      if (load_main)    main_q <= dec;
      if (skid_to_main) main_q <= skid_q;
      if (load_skid)    skid_q <= dec;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_pc    = main_q.pc;
  assign bus.opcode    = main_q.instr[6:0];
  assign bus.rd        = main_q.instr[7 +: REG_AW];
  assign bus.funct3    = main_q.instr[14:12];
  assign bus.rs1       = main_q.instr[15 +: REG_AW];
  assign bus.rs2       = main_q.instr[20 +: REG_AW];
  assign bus.funct7    = main_q.instr[31:25];
  assign bus.imm       = main_q.imm;
  assign bus.fmt       = main_q.fmt;
  assign bus.illegal   = (main_q.fmt == 3'd7);

endmodule

// File: tb/tb_rv_decode_stage.sv
// Drives an RV32 (FENCE enabled) and an RV64 (FENCE disabled) decode stage in lockstep and
// compares both against a queue-based model that decodes from the ISA encoding tables.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        drv_valid = 1'b0, drv_ordy = 1'b0, drv_flush = 1'b0;
  logic [31:0] drv_instr = '0;
  logic [63:0] drv_pc = '0;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  ent_t q[$];
  bit   m_in_ready = 1'b0;

  rv_decode_stage_if #(.XLEN(32), .REG_AW(5)) bus32 ();
  rv_decode_stage_if #(.XLEN(64), .REG_AW(5)) bus64 ();

  rv_decode_stage #(.XLEN(32), .REG_AW(5), .FENCE_EN(1)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32.slave));
  rv_decode_stage #(.XLEN(64), .REG_AW(5), .FENCE_EN(0)) dut64 (
    .clk(clk), .reset(reset), .bus(bus64.slave));

  always #5 clk = ~clk;

  assign bus32.in_valid  = drv_valid;
  assign bus32.in_instr  = drv_instr;
  assign bus32.in_pc     = drv_pc[31:0];
  assign bus32.out_ready = drv_ordy;
  assign bus32.flush     = drv_flush;
  assign bus64.in_valid  = drv_valid;
  assign bus64.in_instr  = drv_instr;
  assign bus64.in_pc     = drv_pc;
  assign bus64.out_ready = drv_ordy;
  assign bus64.flush     = drv_flush;

  function automatic int ref_fmt(logic [31:0] ins, bit fence);
    if (ins[1:0] != 2'b11) return 7;
    case (ins[6:0])
      7'b0110011: return 0;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return 1;
      7'b0001111: return fence ? 1 : 7;
      7'b0100011: return 2;
      7'b1100011: return 3;
      7'b0110111, 7'b0010111: return 4;
      7'b1101111: return 5;
      default: return 7;
    endcase
  endfunction

  // Two's-complement interpretation of a 'bits'-wide field as a 64-bit value.
  function automatic logic [63:0] sext(logic [63:0] v, int bits);
    if (v[bits-1]) return v - (64'd1 << bits);
    return v;
  endfunction

  function automatic logic [163:0] exp_bundle(logic [31:0] ins, logic [63:0] pc, bit is64, bit fence);
    int f;
    logic [63:0] imm;
    logic [63:0] p;
    f = ref_fmt(ins, fence);
    case (f)
      1: imm = sext(64'(ins[31:20]), 12);
      2: imm = sext(64'({ins[31:25], ins[11:7]}), 12);
      3: imm = sext(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      4: imm = sext(64'({ins[31:12], 12'b0}), 32);
      5: imm = sext(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      default: imm = 64'd0;
    endcase
    p = pc;
    if (!is64) begin
      imm = {32'b0, imm[31:0]};
      p   = {32'b0, pc[31:0]};
    end
    return {p, ins[6:0], ins[11:7], ins[14:12], ins[19:15], ins[24:20], ins[31:25],
            imm, 3'(f), (f == 7)};
  endfunction

  function automatic logic [163:0] obs32();
    return {32'b0, bus32.out_pc, bus32.opcode, bus32.rd, bus32.funct3, bus32.rs1, bus32.rs2,
            bus32.funct7, 32'b0, bus32.imm, bus32.fmt, bus32.illegal};
  endfunction

  function automatic logic [163:0] obs64();
    return {bus64.out_pc, bus64.opcode, bus64.rd, bus64.funct3, bus64.rs1, bus64.rs2,
            bus64.funct7, bus64.imm, bus64.fmt, bus64.illegal};
  endfunction

  function automatic logic [327:0] exp_front();
    return {exp_bundle(q[0].instr, q[0].pc, 1'b0, 1'b1), exp_bundle(q[0].instr, q[0].pc, 1'b1, 1'b0)};
  endfunction

  // Advances one clock and updates the model queue from the inputs that were presented.
  task automatic cycle();
    bit   push, pop;
    ent_t e;
    push = drv_valid && m_in_ready && !drv_flush && !reset;
    pop  = (q.size() > 0) && drv_ordy;
    e.instr = drv_instr;
    e.pc    = drv_pc;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      m_in_ready = 1'b0;
    end else if (drv_flush) begin
      q.delete();
      m_in_ready = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      m_in_ready = (q.size() < 2);
    end
  endtask

  task automatic applyStimulus(logic v, logic [31:0] ins, logic [63:0] pc, logic ordy, logic fl);
    drv_valid = v;
    drv_instr = ins;
    drv_pc    = pc;
    drv_ordy  = ordy;
    drv_flush = fl;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    cycle();
    cycle();
    compared++;
    if ({bus32.in_ready, bus32.out_valid, bus64.in_ready, bus64.out_valid} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_hs: got %b want 0000",
               {bus32.in_ready, bus32.out_valid, bus64.in_ready, bus64.out_valid});
    end
    compared++;
    if ({obs32(), obs64()} !== 328'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got %h want 0", {obs32(), obs64()});
    end
    reset = 1'b0;
    cycle();
    compared++;
    if ({bus32.in_ready, bus32.out_valid, bus64.in_ready, bus64.out_valid} !== 4'b1010) begin
      mismatched++;
      $display("[TB] FAIL post_reset_hs: got %b want 1010",
               {bus32.in_ready, bus32.out_valid, bus64.in_ready, bus64.out_valid});
    end
  endtask

  task automatic test_addi();
    applyStimulus(1'b1, 32'h0050_0093, 64'h100, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    compared++;
    if ({bus32.out_valid, bus32.fmt, bus32.rd, bus32.rs1, bus32.imm, bus32.out_pc} !==
        {1'b1, 3'd1, 5'd1, 5'd0, 32'd5, 32'h100}) begin
      mismatched++;
      $display("[TB] FAIL addi32: got v=%b fmt=%0d rd=%0d rs1=%0d imm=%h pc=%h", bus32.out_valid,
               bus32.fmt, bus32.rd, bus32.rs1, bus32.imm, bus32.out_pc);
    end
    compared++;
    if (q.size() != 1 || {obs32(), obs64()} !== exp_front()) begin
      mismatched++;
      $display("[TB] FAIL addi_model: got %h want %h (model depth %0d)", {obs32(), obs64()},
               q.size() != 0 ? exp_front() : 328'd0, q.size());
    end
    cycle();
  endtask

  task automatic test_branch();
    applyStimulus(1'b1, 32'hFE01_0EE3, 64'hFFFF_0000_0000_0200, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    compared++;
    if ({bus32.fmt, bus32.imm, bus64.fmt, bus64.imm} !==
        {3'd3, 32'hFFFF_FFFC, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC}) begin
      mismatched++;
      $display("[TB] FAIL beq_imm: got fmt=%0d imm=%h / fmt=%0d imm=%h", bus32.fmt, bus32.imm,
               bus64.fmt, bus64.imm);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    int popped;
    w[0] = 32'h0010_8113; w[1] = 32'h0020_A023; w[2] = 32'h8000_02B7;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, w[i], 64'h400 + 64'(4 * i), 1'b0, 1'b0);
      cycle();
    end
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    compared++;
    if ({bus32.in_ready, bus64.in_ready, 2'(q.size())} !== {1'b0, 1'b0, 2'd2}) begin
      mismatched++;
      $display("[TB] FAIL b2b_full: got in_ready=%b/%b depth=%0d want 0/0 2", bus32.in_ready,
               bus64.in_ready, q.size());
    end
    drv_ordy = 1'b1;
    popped = 0;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (bus32.out_valid !== (q.size() > 0) ||
          (q.size() > 0 && {obs32(), obs64()} !== exp_front())) begin
        mismatched++;
        $display("[TB] FAIL b2b_drain%0d: got v=%b %h", i, bus32.out_valid, {obs32(), obs64()});
      end
      if (q.size() > 0 && q[0].instr == w[popped]) popped++;
      cycle();
    end
    compared++;
    if (popped !== 2) begin
      mismatched++;
      $display("[TB] FAIL b2b_order: got %0d in-order words want 2", popped);
    end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 32'h0000_0513, 64'h800, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 32'h0000_0593, 64'h804, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 32'h0000_0613, 64'h808, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    compared++;
    if ({bus32.out_valid, bus32.in_ready, bus64.out_valid, bus64.in_ready} !== 4'b0101) begin
      mismatched++;
      $display("[TB] FAIL flush_hs: got %b want 0101",
               {bus32.out_valid, bus32.in_ready, bus64.out_valid, bus64.in_ready});
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      compared++;
      if ({bus32.out_valid, bus64.out_valid} !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL flush_drop%0d: got out_valid %b want 00", i,
                 {bus32.out_valid, bus64.out_valid});
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w[3];
    w[0] = 32'h0000_007F; w[1] = 32'h0000_0010; w[2] = 32'h0000_000F;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, w[i], 64'h900 + 64'(4 * i), 1'b1, 1'b0);
      cycle();
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      compared++;
      if (q.size() != 1 || {obs32(), obs64()} !== exp_front()) begin
        mismatched++;
        $display("[TB] FAIL illegal_word%0d: got %h", i, {obs32(), obs64()});
      end
    end
    compared++;
    if ({bus64.illegal, bus64.fmt, bus32.illegal, bus32.fmt} !== {1'b1, 3'd7, 1'b0, 3'd1}) begin
      mismatched++;
      $display("[TB] FAIL fence_cfg: got ill64=%b fmt64=%0d ill32=%b fmt32=%0d", bus64.illegal,
               bus64.fmt, bus32.illegal, bus32.fmt);
    end
    cycle();
  endtask

  task automatic test_random();
    logic [6:0]  ops[11];
    logic [31:0] r;
    logic [63:0] pc;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    for (int i = 0; i < 400; i++) begin
      r  = $urandom;
      pc = {32'($urandom), 32'($urandom)} & ~64'd3;
      if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 10)];
      applyStimulus(1'($urandom_range(0, 3) != 0), r, pc, 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 15) == 0));
      cycle();
      compared++;
      if ({bus32.in_ready, bus32.out_valid, bus64.in_ready, bus64.out_valid} !==
          {m_in_ready, q.size() > 0, m_in_ready, q.size() > 0}) begin
        mismatched++;
        $display("[TB] FAIL rand_hs%0d: got %b want %b", i,
                 {bus32.in_ready, bus32.out_valid, bus64.in_ready, bus64.out_valid},
                 {m_in_ready, q.size() > 0, m_in_ready, q.size() > 0});
      end
      if (q.size() > 0) begin
        compared++;
        if ({obs32(), obs64()} !== exp_front()) begin
          mismatched++;
          $display("[TB] FAIL rand_data%0d: got %h want %h", i, {obs32(), obs64()}, exp_front());
        end
      end
    end
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    cycle();
    cycle();
    cycle();
  endtask

  task automatic test_reset_full();
    applyStimulus(1'b1, 32'h0000_0A13, 64'hA00, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 32'h0000_0A93, 64'hA04, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    reset = 1'b1;
    cycle();
    compared++;
    if ({bus32.in_ready, bus32.out_valid, bus64.in_ready, bus64.out_valid} !== 4'b0000 ||
        {obs32(), obs64()} !== 328'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_full: got hs=%b data=%h want 0000/0",
               {bus32.in_ready, bus32.out_valid, bus64.in_ready, bus64.out_valid}, {obs32(), obs64()});
    end
    reset = 1'b0;
    cycle();
    compared++;
    if ({bus32.in_ready, bus32.out_valid, bus64.in_ready, bus64.out_valid} !== 4'b1010) begin
      mismatched++;
      $display("[TB] FAIL reset_full_release: got %b want 1010",
               {bus32.in_ready, bus32.out_valid, bus64.in_ready, bus64.out_valid});
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
